// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared frame sizing and reset constants for the SIPO deserializer (SIPO_PARITY_EN adds a parity bit)
package sipo_pkg;

`ifdef SIPO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam logic RST_VALID   = 1'b0;
  localparam logic RST_OVERRUN = 1'b0;
  localparam logic RST_PERR    = 1'b0;

  // Frame length in serial bits for a given data width.
  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

  function automatic int cnt_width(input int frame);
    return (frame > 1) ? $clog2(frame) : 1;
  endfunction

endpackage

// File: rtl/sipo_rt_deserializer_if.sv
// rtl/sipo_rt_deserializer_if.sv - serial input and parallel valid/ready output bundle
interface sipo_rt_deserializer_if #(parameter int WIDTH = 4);
  logic             s_in;
  logic             s_valid;
  logic             clear;
  logic [WIDTH-1:0] p_data;
  logic             p_valid;
  logic             p_ready;
  logic             parity_err;
  logic             overrun;

  modport master (
    output s_in, s_valid, clear, p_ready,
    input  p_data, p_valid, parity_err, overrun
  );

  modport slave (
    input  s_in, s_valid, clear, p_ready,
    output p_data, p_valid, parity_err, overrun
  );
endinterface

// File: rtl/sipo_bit_counter.sv
// rtl/sipo_bit_counter.sv - mod-FRAME bit position counter with sync clear and last-bit flag
module sipo_bit_counter #(
  parameter int FRAME = 4,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          last
);

  logic at_end;

  assign at_end = (count == CW'(FRAME - 1));
  assign last   = en & at_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_end ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_rt_deserializer.sv
// rtl/sipo_rt_deserializer.sv - LSB-first serial-to-parallel receiver with valid/ready output and sticky overrun
// Optional odd parity bit per frame when SIPO_PARITY_EN is defined.
module sipo_rt_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sipo_rt_deserializer_if.slave bus
);

  localparam int FRAME = frame_len(WIDTH);
  localparam int CW    = cnt_width(FRAME);

  logic [CW-1:0]    count;
  logic             last;
  logic             data_bit;
  logic             complete;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] p_data_q;
  logic             p_valid_q;
  logic             overrun_q;

  sipo_bit_counter #(
    .FRAME (FRAME),
    .CW    (CW)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (bus.s_valid),
    .clr     (bus.clear),
    .count   (count),
    .last    (last)
  );

  // The trailing parity bit, when present, never enters the shift register.
  assign data_bit = int'(count) < WIDTH;
  assign complete = last & ~bus.clear;

`ifdef SIPO_PARITY_EN
  logic perr_q;
  logic perr_next;

  assign word      = shreg;
  assign perr_next = ~(^shreg ^ bus.s_in);
`else
  assign word      = {bus.s_in, shreg[WIDTH-1:1]};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
    end else if (bus.clear) begin
      shreg <= '0;
    end else if (bus.s_valid && data_bit) begin
      shreg <= {bus.s_in, shreg[WIDTH-1:1]};
    end
  end

  // A word completing while the consumer accepts the previous one replaces it directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_data_q  <= '0;
      p_valid_q <= RST_VALID;
      overrun_q <= RST_OVERRUN;
    end else if (bus.clear) begin
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (complete) begin
      if (!p_valid_q || bus.p_ready) begin
        p_data_q  <= word;
        p_valid_q <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (p_valid_q && bus.p_ready) begin
      p_valid_q <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_q <= RST_PERR;
    end else if (!bus.clear && complete && (!p_valid_q || bus.p_ready)) begin
      perr_q <= perr_next;
    end
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = RST_PERR;
`endif

  assign bus.p_data  = p_data_q;
  assign bus.p_valid = p_valid_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_sipo_rt_deserializer.sv
// tb/tb_sipo_rt_deserializer.sv - self-checking bench for sipo_rt_deserializer with a word-level reference model
module tb_sipo_rt_deserializer;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam int FR = W + 1;
`else
  localparam int FR = W;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  sipo_rt_deserializer_if #(.WIDTH(W)) bus ();

  sipo_rt_deserializer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: bits collected so far, their value, and the expected output register.
  int           nbits = 0;
  int           acc = 0;
  int           pbit = 0;
  logic         exp_valid = 1'b0;
  logic [W-1:0] exp_data = '0;
  logic         exp_ovr = 1'b0;
  logic         exp_perr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string where);
    check({where, " p_valid"}, 32'(bus.p_valid), 32'(exp_valid));
    check({where, " p_data"}, 32'(bus.p_data), 32'(exp_data));
    check({where, " overrun"}, 32'(bus.overrun), 32'(exp_ovr));
    check({where, " parity_err"}, 32'(bus.parity_err), 32'(exp_perr));
  endtask

  task automatic model_reset();
    nbits = 0; acc = 0; pbit = 0;
    exp_valid = 1'b0; exp_data = '0; exp_ovr = 1'b0; exp_perr = 1'b0;
  endtask

  function automatic logic odd_parity_fail(input int data, input int p);
    int ones = p;
    for (int i = 0; i < W; i++) ones += (data >> i) & 1;
    return (ones % 2) == 0;
  endfunction

  task automatic model_edge(input logic b, input logic v, input logic rdy, input logic clr);
    logic done = 1'b0;
    if (!reset_n) begin
      model_reset();
    end else if (clr) begin
      nbits = 0; acc = 0;
      exp_valid = 1'b0; exp_ovr = 1'b0;
    end else begin
      if (v) begin
        if (nbits < W) acc += int'(b) << nbits;
        else pbit = int'(b);
        nbits++;
        if (nbits == FR) begin
          done = 1'b1;
          nbits = 0;
        end
      end
      if (done) begin
        if (!exp_valid || rdy) begin
          exp_valid = 1'b1;
          exp_data  = W'(acc);
`ifdef SIPO_PARITY_EN
          exp_perr  = odd_parity_fail(acc, pbit);
`endif
        end else begin
          exp_ovr = 1'b1;
        end
        acc = 0;
      end else if (exp_valid && rdy) begin
        exp_valid = 1'b0;
      end
    end
  endtask

  task automatic step(input logic b, input logic v, input logic rdy, input logic clr);
    bus.s_in = b; bus.s_valid = v; bus.p_ready = rdy; bus.clear = clr;
    @(posedge clk);
    model_edge(b, v, rdy, clr);
    #1;
    check_outputs("step");
  endtask

  task automatic send(input logic [W-1:0] w, input logic par, input int gap_lo, input int gap_hi,
                      input logic rdy, input logic last_rdy);
    for (int i = 0; i < FR; i++) begin
      if (i > 0 && gap_hi > 0) begin
        int g = $urandom_range(gap_hi, gap_lo);
        for (int k = 0; k < g; k++) step(1'($urandom), 1'b0, rdy, 1'b0);
      end
      step((i < W) ? w[i] : par, 1'b1, (i == FR - 1) ? last_rdy : rdy, 1'b0);
    end
  endtask

  function automatic logic odd_par(input logic [W-1:0] w);
    return ~(^w);
  endfunction

  initial begin
    bus.s_in = 1'b0; bus.s_valid = 1'b0; bus.p_ready = 1'b0; bus.clear = 1'b0;
    model_reset();

    // Reset held with random serial activity.
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    check("reset p_valid", 32'(bus.p_valid), 32'h0);
    check("reset p_data", 32'(bus.p_data), 32'h0);
    check("reset overrun", 32'(bus.overrun), 32'h0);
    reset_n = 1'b1;

    send(4'hD, odd_par(4'hD), 0, 0, 1'b0, 1'b0);
    check("first word valid", 32'(bus.p_valid), 32'h1);
    check("first word data", 32'(bus.p_data), 32'hD);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("first word accepted", 32'(bus.p_valid), 32'h0);

    // Back-to-back with consumer always ready.
    send(4'h3, odd_par(4'h3), 0, 0, 1'b1, 1'b1);
    check("b2b word3", 32'(bus.p_data), 32'h3);
    check("b2b valid3", 32'(bus.p_valid), 32'h1);
    send(4'hA, odd_par(4'hA), 0, 0, 1'b1, 1'b1);
    check("b2b wordA", 32'(bus.p_data), 32'hA);
    check("b2b overrun", 32'(bus.overrun), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Gapped serial input.
    send(4'h6, odd_par(4'h6), 2, 5, 1'b0, 1'b0);
    check("gapped data", 32'(bus.p_data), 32'h6);
    check("gapped valid", 32'(bus.p_valid), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun while the consumer stalls.
    send(4'h5, odd_par(4'h5), 0, 0, 1'b0, 1'b0);
    send(4'h9, odd_par(4'h9), 0, 0, 1'b0, 1'b0);
    check("overrun data kept", 32'(bus.p_data), 32'h5);
    check("overrun flag", 32'(bus.overrun), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("overrun drained", 32'(bus.p_valid), 32'h0);
    check("overrun sticky", 32'(bus.overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("overrun cleared", 32'(bus.overrun), 32'h0);

    // Accept and completion on the same edge.
    send(4'h2, odd_par(4'h2), 0, 0, 1'b0, 1'b0);
    send(4'hC, odd_par(4'hC), 0, 0, 1'b0, 1'b1);
    check("simul valid", 32'(bus.p_valid), 32'h1);
    check("simul data", 32'(bus.p_data), 32'hC);
    check("simul overrun", 32'(bus.overrun), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear on the final bit drops that frame without overrun.
    for (int i = 0; i < FR - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("clear last valid", 32'(bus.p_valid), 32'h0);
    check("clear last overrun", 32'(bus.overrun), 32'h0);
    send(4'h4, odd_par(4'h4), 0, 0, 1'b0, 1'b0);
    check("after clear data", 32'(bus.p_data), 32'h4);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame discards partial word.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async reset p_data", 32'(bus.p_data), 32'h0);
    for (int i = 0; i < 2; i++) step(1'($urandom), 1'($urandom), 1'b0, 1'b0);
    reset_n = 1'b1;
    send(4'hB, odd_par(4'hB), 0, 0, 1'b0, 1'b0);
    check("post reset data", 32'(bus.p_data), 32'hB);
    step(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SIPO_PARITY_EN
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send(4'h7, 1'b0, 0, 0, 1'b0, 1'b0);
    check("parity good data", 32'(bus.p_data), 32'h7);
    check("parity good flag", 32'(bus.parity_err), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send(4'h7, 1'b1, 0, 0, 1'b0, 1'b0);
    check("parity bad flag", 32'(bus.parity_err), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic: random bits, gaps, ready and rare clears.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), ($urandom_range(3, 0) != 0), 1'($urandom),
           ($urandom_range(40, 0) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
